// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with wrap-around or ping-pong (bounce) mode,
// synchronous clear/load, terminal count and registered wrap pulse.
module updown_mod_counter #(
  parameter int unsigned WIDTH     = 3,
  parameter int unsigned MAX_COUNT = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             updown,
  input  logic             pingpong,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             dir,
  output logic             tc,
  output logic             wrap
);

  localparam longint unsigned max_legal = (64'd1 << WIDTH) - 64'd1;

  // Reject illegal parameterisations at elaboration time
  generate
    if (WIDTH < 1 || WIDTH > 32 || MAX_COUNT < 1 || 64'(MAX_COUNT) > max_legal) begin : g_bad_param
      $error("updown_mod_counter: illegal WIDTH/MAX_COUNT combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] max_q = WIDTH'(MAX_COUNT);

  logic             dir_r;
  logic             dir_n;
  logic             wrap_n;
  logic             step_up;
  logic [WIDTH-1:0] q_n;

  assign qb  = ~q;
  assign dir = pingpong ? dir_r : updown;
  assign tc  = dir ? (q == max_q) : (q == '0);

  // Next-state: clr > load > step > hold
  always_comb begin
    q_n     = q;
    wrap_n  = 1'b0;
    dir_n   = dir_r;
    step_up = dir_r;
    if (clr) begin
      q_n = '0;
    end else if (load) begin
      q_n = (din > max_q) ? max_q : din;
    end else begin
      if (!pingpong) begin
        dir_n = updown;
      end
      if (en) begin
        if (!pingpong) begin
          if (updown) begin
            if (q == max_q) begin
              q_n    = '0;
              wrap_n = 1'b1;
            end else begin
              q_n = q + WIDTH'(1);
            end
          end else begin
            if (q == '0) begin
              q_n    = max_q;
              wrap_n = 1'b1;
            end else begin
              q_n = q - WIDTH'(1);
            end
          end
        end else begin
          // At an end point the bounce and the step happen on the same edge
          step_up = tc ? ~dir_r : dir_r;
          dir_n   = step_up;
          q_n     = step_up ? (q + WIDTH'(1)) : (q - WIDTH'(1));
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      wrap  <= 1'b0;
      dir_r <= 1'b1;
    end else begin
      q     <= q_n;
      wrap  <= wrap_n;
      dir_r <= dir_n;
    end
  end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: three parameterisations share one stimulus
// stream; directed vectors, an async-reset sequence and random traffic.
module tb_updown_mod_counter;

  logic       clk = 1'b0;
  logic       rst, en, updown, pingpong, clr, load;
  logic [3:0] din;

  always #5 clk = ~clk;

  logic [2:0] q_a, qb_a;
  logic [3:0] q_b, qb_b;
  logic [2:0] q_c, qb_c;
  logic       dir_a, tc_a, wrap_a, dir_b, tc_b, wrap_b, dir_c, tc_c, wrap_c;

  updown_mod_counter #(.WIDTH(3), .MAX_COUNT(7)) u_a (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .pingpong(pingpong),
    .clr(clr), .load(load), .din(din[2:0]),
    .q(q_a), .qb(qb_a), .dir(dir_a), .tc(tc_a), .wrap(wrap_a));

  updown_mod_counter #(.WIDTH(4), .MAX_COUNT(9)) u_b (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .pingpong(pingpong),
    .clr(clr), .load(load), .din(din),
    .q(q_b), .qb(qb_b), .dir(dir_b), .tc(tc_b), .wrap(wrap_b));

  updown_mod_counter #(.WIDTH(3), .MAX_COUNT(3)) u_c (
    .clk(clk), .rst(rst), .en(en), .updown(updown), .pingpong(pingpong),
    .clr(clr), .load(load), .din(din[2:0]),
    .q(q_c), .qb(qb_c), .dir(dir_c), .tc(tc_c), .wrap(wrap_c));

  logic [3:0] dq [3];
  logic [3:0] dqb[3];
  logic       ddir[3], dtc[3], dwrap[3];

  assign dq[0] = {1'b0, q_a};  assign dqb[0] = {1'b0, qb_a};
  assign dq[1] = q_b;          assign dqb[1] = qb_b;
  assign dq[2] = {1'b0, q_c};  assign dqb[2] = {1'b0, qb_c};
  assign ddir[0] = dir_a;  assign dtc[0] = tc_a;  assign dwrap[0] = wrap_a;
  assign ddir[1] = dir_b;  assign dtc[1] = tc_b;  assign dwrap[1] = wrap_b;
  assign ddir[2] = dir_c;  assign dtc[2] = tc_c;  assign dwrap[2] = wrap_c;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: count, bounce direction, wrap pulse
  int mx [3] = '{7, 9, 3};
  int msk[3] = '{7, 15, 7};
  int m_q[3], m_dir[3], m_wrap[3];

  typedef struct {
    logic c, l, e, u, p;
    int   d;
    int   qa, qb, qc;
    logic wa, wb, wc;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, idx, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_q[i] = 0; m_dir[i] = 1; m_wrap[i] = 0;
    end
  endtask

  // Counter rules applied with plain integer arithmetic
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int v, d;
      m_wrap[i] = 0;
      if (clr) begin
        m_q[i] = 0;
      end else if (load) begin
        v = int'(din) & msk[i];
        m_q[i] = (v > mx[i]) ? mx[i] : v;
      end else begin
        if (!pingpong) m_dir[i] = int'(updown);
        if (en) begin
          if (!pingpong) begin
            if (updown) begin
              m_wrap[i] = (m_q[i] == mx[i]) ? 1 : 0;
              m_q[i] = (m_q[i] + 1) % (mx[i] + 1);
            end else begin
              m_wrap[i] = (m_q[i] == 0) ? 1 : 0;
              m_q[i] = (m_q[i] + mx[i]) % (mx[i] + 1);
            end
          end else begin
            d = (m_dir[i] != 0) ? 1 : -1;
            if (m_q[i] + d < 0 || m_q[i] + d > mx[i]) begin
              m_dir[i] = 1 - m_dir[i];
              d = -d;
            end
            m_q[i] = m_q[i] + d;
          end
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      int eff;
      eff = pingpong ? m_dir[i] : int'(updown);
      chk({tag, ".q"},    i, int'(dq[i]),   m_q[i]);
      chk({tag, ".qb"},   i, int'(dqb[i]),  (~m_q[i]) & msk[i]);
      chk({tag, ".dir"},  i, int'(ddir[i]), eff);
      chk({tag, ".tc"},   i, int'(dtc[i]),  (eff != 0) ? int'(m_q[i] == mx[i]) : int'(m_q[i] == 0));
      chk({tag, ".wrap"}, i, int'(dwrap[i]), m_wrap[i]);
    end
  endtask

  task automatic drive(input logic c, l, e, u, p, input int d);
    clr = c; load = l; en = e; updown = u; pingpong = p; din = 4'(d);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic addv(input logic c, l, e, u, p, input int d,
                      input int qa, qb, qc, input logic wa, wb, wc);
    vec_t v;
    v = '{c, l, e, u, p, d, qa, qb, qc, wa, wb, wc};
    vt.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Up count, wrap-around
    addv(0,0,1,1,0,0, 1,1,1, 0,0,0);
    addv(0,0,1,1,0,0, 2,2,2, 0,0,0);
    addv(0,0,1,1,0,0, 3,3,3, 0,0,0);
    addv(0,0,1,1,0,0, 4,4,0, 0,0,1);
    addv(0,0,1,1,0,0, 5,5,1, 0,0,0);
    addv(0,0,1,1,0,0, 6,6,2, 0,0,0);
    addv(0,0,1,1,0,0, 7,7,3, 0,0,0);
    addv(0,0,1,1,0,0, 0,8,0, 1,0,1);
    addv(0,0,1,1,0,0, 1,9,1, 0,0,0);
    // Clear, then down count through the wrap
    addv(1,0,1,1,0,0, 0,0,0, 0,0,0);
    addv(0,0,1,0,0,0, 7,9,3, 1,1,1);
    addv(0,0,1,0,0,0, 6,8,2, 0,0,0);
    addv(0,0,1,0,0,0, 5,7,1, 0,0,0);
    // Load with clamping, clr over load, hold
    addv(0,1,1,0,0,7,  7,7,3, 0,0,0);
    addv(1,1,1,0,0,12, 0,0,0, 0,0,0);
    addv(0,1,0,0,0,12, 4,9,3, 0,0,0);
    addv(0,0,0,1,0,0,  4,9,3, 0,0,0);
    addv(1,0,0,1,0,0,  0,0,0, 0,0,0);
    // Ping-pong with updown held low (ignored)
    addv(0,0,1,0,1,0, 1,1,1, 0,0,0);
    addv(0,0,1,0,1,0, 2,2,2, 0,0,0);
    addv(0,0,1,0,1,0, 3,3,3, 0,0,0);
    addv(0,0,1,0,1,0, 4,4,2, 0,0,0);
    addv(0,0,1,0,1,0, 5,5,1, 0,0,0);
    addv(0,0,1,0,1,0, 6,6,0, 0,0,0);
    addv(0,0,1,0,1,0, 7,7,1, 0,0,0);
    addv(0,0,1,0,1,0, 6,8,2, 0,0,0);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check_model("reset");
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[k]) begin
      drive(vt[k].c, vt[k].l, vt[k].e, vt[k].u, vt[k].p, vt[k].d);
      step("vec");
      chk("vec.qa", k, int'(q_a), vt[k].qa);
      chk("vec.qb", k, int'(q_b), vt[k].qb);
      chk("vec.qc", k, int'(q_c), vt[k].qc);
      chk("vec.wa", k, int'(wrap_a), int'(vt[k].wa));
      chk("vec.wb", k, int'(wrap_b), int'(vt[k].wb));
      chk("vec.wc", k, int'(wrap_c), int'(vt[k].wc));
    end

    // Async reset mid-cycle while u_a holds q=6 counting down
    en = 1'b0;
    #1;
    chk("pre_rst.q", 0, int'(q_a), 6);
    chk("pre_rst.dir", 0, int'(dir_a), 0);
    rst = 1'b1;
    #1;
    chk("async_rst.q_a", 0, int'(q_a), 0);
    chk("async_rst.qb_a", 0, int'(qb_a), 7);
    chk("async_rst.qb_b", 1, int'(qb_b), 15);
    chk("async_rst.dir_a", 0, int'(dir_a), 1);
    chk("async_rst.wrap_a", 0, int'(wrap_a), 0);
    model_reset();
    check_model("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst_hold");
    chk("post_rst_hold.q", 0, int'(q_a), 0);
    en = 1'b1;
    step("post_rst_step");
    chk("post_rst_step.q", 0, int'(q_a), 1);

    // Random traffic in both modes against the model
    for (int n = 0; n < 10000; n++) begin
      logic p;
      p = pingpong;
      if ($urandom_range(49) == 0) p = ~p;
      if ($urandom_range(499) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        check_model("rnd_rst");
        rst = 1'b0;
      end
      drive(1'($urandom_range(19) == 0), 1'($urandom_range(19) == 0),
            1'($urandom_range(9) < 7), 1'($urandom_range(1)), p,
            int'($urandom_range(15)));
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
